// File: rtl/gpu_pkg.sv
// Shared types and constants for the rect-copy link between CPU data RAM and the GPU.
package gpu_pkg;

    localparam int unsigned WORDS_PER_RECT = 5;

    // Tag widths as seen on the link
    localparam int unsigned FIELD_BITS = 3;
    localparam int unsigned RECT_BITS  = 4;
    localparam int unsigned BATCH_BITS = 2;
    localparam int unsigned INDEX_BITS = 10;

    typedef enum logic [FIELD_BITS-1:0] {
        FIELD_X      = 3'd0,
        FIELD_Y      = 3'd1,
        FIELD_WIDTH  = 3'd2,
        FIELD_HEIGHT = 3'd3,
        FIELD_COLOR  = 3'd4
    } field_e;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StRead,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/rect_word_counter.sv
// Nested field/rect/batch counters plus the flat word index of the word being read.
module rect_word_counter
    import gpu_pkg::*;
#(
    parameter int unsigned RECT_COUNT      = 64,
    parameter int unsigned RECTS_PER_BATCH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    input  logic                  clear,
    output logic [FIELD_BITS-1:0] field,
    output logic [RECT_BITS-1:0]  rect,
    output logic [BATCH_BITS-1:0] batch,
    output logic [INDEX_BITS-1:0] index,
    output logic                  last_word,
    output logic                  last_in_batch
);

    field_e                field_q;
    logic [RECT_BITS-1:0]  rect_q;
    logic [BATCH_BITS-1:0] batch_q;
    logic [INDEX_BITS-1:0] index_q;

    // Field rolls into rect, rect rolls into batch; clear wins over inc
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            field_q <= FIELD_X;
            rect_q  <= '0;
            batch_q <= '0;
            index_q <= '0;
        end else if (inc) begin
            index_q <= index_q + 1'b1;
            if (field_q == FIELD_COLOR) begin
                field_q <= FIELD_X;
                if (rect_q == RECT_BITS'(RECTS_PER_BATCH - 1)) begin
                    rect_q  <= '0;
                    batch_q <= batch_q + 1'b1;
                end else begin
                    rect_q <= rect_q + 1'b1;
                end
            end else begin
                field_q <= field_e'(field_q + 3'd1);
            end
        end
    end

    // Flags describe the word currently addressed
    always_comb begin
        field         = field_q;
        rect          = rect_q;
        batch         = batch_q;
        index         = index_q;
        last_word     = (index_q == INDEX_BITS'(RECT_COUNT * WORDS_PER_RECT - 1));
        last_in_batch = (field_q == FIELD_COLOR) &&
                        (rect_q == RECT_BITS'(RECTS_PER_BATCH - 1));
    end

endmodule

// File: rtl/rect_stream_tx.sv
// Reads the rect table from CPU data RAM on each frame trigger and streams it, tagged, to the GPU.
module rect_stream_tx
    import gpu_pkg::*;
#(
    parameter int unsigned           RECT_COUNT      = 64,
    parameter int unsigned           RECTS_PER_BATCH = 16,
    parameter int unsigned           ADDR_WIDTH      = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_re,
    input  logic [15:0]           mem_rdata,
    output logic                  copy_start,
    output logic                  tx_valid,
    output logic [15:0]           tx_data,
    output logic [FIELD_BITS-1:0] fsm_state,
    output logic [INDEX_BITS-1:0] coord_generator,
    output logic [RECT_BITS-1:0]  rect_counter,
    output logic [BATCH_BITS-1:0] batch_counter,
    output logic                  batch_completed,
    output logic                  busy,
    output logic                  done
);

    state_e state_q, state_d;

    logic                  cnt_inc, cnt_clear;
    logic [FIELD_BITS-1:0] cnt_field;
    logic [RECT_BITS-1:0]  cnt_rect;
    logic [BATCH_BITS-1:0] cnt_batch;
    logic [INDEX_BITS-1:0] cnt_index;
    logic                  cnt_last_word, cnt_last_in_batch;

    // Tags of the read in flight, aligned with mem_rdata one cycle later
    logic                  s1_valid;
    logic [FIELD_BITS-1:0] s1_field;
    logic [RECT_BITS-1:0]  s1_rect;
    logic [BATCH_BITS-1:0] s1_batch;
    logic [INDEX_BITS-1:0] s1_index;
    logic                  s1_batch_end;
    logic                  s1_last;
    logic                  tx_last;

    rect_word_counter #(
        .RECT_COUNT      (RECT_COUNT),
        .RECTS_PER_BATCH (RECTS_PER_BATCH)
    ) u_counter (
        .clk           (clk),
        .reset         (reset),
        .inc           (cnt_inc),
        .clear         (cnt_clear),
        .field         (cnt_field),
        .rect          (cnt_rect),
        .batch         (cnt_batch),
        .index         (cnt_index),
        .last_word     (cnt_last_word),
        .last_in_batch (cnt_last_in_batch)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, read issue and strobes
    always_comb begin
        state_d    = state_q;
        copy_start = 1'b0;
        mem_re     = 1'b0;
        done       = 1'b0;
        cnt_inc    = 1'b0;
        cnt_clear  = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_clear = 1'b1;
                if (frame_start) state_d = StStart;
            end
            StStart: begin
                copy_start = 1'b1;
                mem_re     = 1'b1;
                cnt_inc    = 1'b1;
                state_d    = StRead;
            end
            StRead: begin
                mem_re  = 1'b1;
                cnt_inc = 1'b1;
                if (cnt_last_word) state_d = StDrain;
            end
            StDrain: begin
                // Hold until the last word has been presented on the link
                if (tx_valid && tx_last) state_d = StDone;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Address generator; wraps modulo 2^ADDR_WIDTH
    always_comb begin
        mem_addr = '0;
        busy     = (state_q != StIdle);
        if (mem_re) mem_addr = BASE_ADDR + ADDR_WIDTH'(cnt_index);
    end

    // One-stage tag delay matching the RAM read latency
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid     <= 1'b0;
            s1_field     <= '0;
            s1_rect      <= '0;
            s1_batch     <= '0;
            s1_index     <= '0;
            s1_batch_end <= 1'b0;
            s1_last      <= 1'b0;
        end else begin
            s1_valid     <= mem_re;
            s1_field     <= cnt_field;
            s1_rect      <= cnt_rect;
            s1_batch     <= cnt_batch;
            s1_index     <= cnt_index;
            s1_batch_end <= cnt_last_in_batch;
            s1_last      <= cnt_last_word;
        end
    end

    // Output register: data and tags update together and hold while idle
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_valid        <= 1'b0;
            tx_data         <= '0;
            fsm_state       <= '0;
            coord_generator <= '0;
            rect_counter    <= '0;
            batch_counter   <= '0;
            batch_completed <= 1'b0;
            tx_last         <= 1'b0;
        end else begin
            tx_valid        <= s1_valid;
            batch_completed <= s1_valid && s1_batch_end;
            tx_last         <= s1_valid && s1_last;
            if (s1_valid) begin
                tx_data         <= mem_rdata;
                fsm_state       <= s1_field;
                coord_generator <= s1_index;
                rect_counter    <= s1_rect;
                batch_counter   <= s1_batch;
            end
        end
    end

endmodule

// File: tb/tb_rect_stream_tx.sv
// Scoreboard bench for rect_stream_tx: expected words and strobe cycles are queued at stimulus
// time and popped by a monitor whenever the DUT presents them.
module tb_rect_stream_tx;

    localparam int N = 320;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, frame_start, fs_w;
    logic [15:0] mem_addr, mem_rdata, tx_data;
    logic        mem_re, copy_start, tx_valid, batch_completed, busy, done;
    logic [2:0]  fsm_state;
    logic [9:0]  coord_generator;
    logic [3:0]  rect_counter;
    logic [1:0]  batch_counter;

    logic [15:0] w_mem_addr, w_mem_rdata, w_tx_data;
    logic        w_mem_re, w_copy_start, w_tx_valid, w_batch_completed, w_busy, w_done;
    logic [2:0]  w_fsm_state;
    logic [9:0]  w_coord_generator;
    logic [3:0]  w_rect_counter;
    logic [1:0]  w_batch_counter;

    rect_stream_tx dut (
        .clk (clk), .reset (reset), .frame_start (frame_start),
        .mem_addr (mem_addr), .mem_re (mem_re), .mem_rdata (mem_rdata),
        .copy_start (copy_start), .tx_valid (tx_valid), .tx_data (tx_data),
        .fsm_state (fsm_state), .coord_generator (coord_generator),
        .rect_counter (rect_counter), .batch_counter (batch_counter),
        .batch_completed (batch_completed), .busy (busy), .done (done)
    );

    rect_stream_tx #(.BASE_ADDR (16'hFFF0)) dut_w (
        .clk (clk), .reset (reset), .frame_start (fs_w),
        .mem_addr (w_mem_addr), .mem_re (w_mem_re), .mem_rdata (w_mem_rdata),
        .copy_start (w_copy_start), .tx_valid (w_tx_valid), .tx_data (w_tx_data),
        .fsm_state (w_fsm_state), .coord_generator (w_coord_generator),
        .rect_counter (w_rect_counter), .batch_counter (w_batch_counter),
        .batch_completed (w_batch_completed), .busy (w_busy), .done (w_done)
    );

    // RAM models: RAM[BASE+k] = k ^ A5A5, one-cycle read latency
    always @(posedge clk) if (mem_re) mem_rdata <= mem_addr ^ 16'hA5A5;
    always @(posedge clk) if (w_mem_re) w_mem_rdata <= (w_mem_addr - 16'hFFF0) ^ 16'hA5A5;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  f;
        logic [9:0]  k;
        logic [3:0]  r;
        logic [1:0]  b;
        logic        bc;
        int          at;
    } exp_t;

    exp_t sb[$];
    int   exp_copy[$];
    int   exp_done[$];

    // Hand-computed tags at selected word indices
    int hk[6] = '{0, 4, 5, 79, 80, 319};
    int hf[6] = '{0, 4, 0, 4, 0, 4};
    int hr[6] = '{0, 0, 1, 15, 0, 15};
    int hb[6] = '{0, 0, 0, 0, 1, 3};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // s is the cycle at which frame_start is raised (frame cycle 0)
    task automatic push_frame(input int s);
        exp_t e;
        for (int k = 0; k < N; k++) begin
            e.data = 16'(k) ^ 16'hA5A5;
            e.f    = 3'(k % 5);
            e.k    = 10'(k);
            e.r    = 4'((k / 5) % 16);
            e.b    = 2'(k / 80);
            e.bc   = ((k % 80) == 79);
            e.at   = s + 3 + k;
            sb.push_back(e);
        end
        exp_copy.push_back(s + 1);
        exp_done.push_back(s + N + 3);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " mem_addr"}, 32'(mem_addr), 0);
        chk({tag, " mem_re"}, 32'(mem_re), 0);
        chk({tag, " copy_start"}, 32'(copy_start), 0);
        chk({tag, " tx_valid"}, 32'(tx_valid), 0);
        chk({tag, " tx_data"}, 32'(tx_data), 0);
        chk({tag, " fsm_state"}, 32'(fsm_state), 0);
        chk({tag, " coord_generator"}, 32'(coord_generator), 0);
        chk({tag, " rect_counter"}, 32'(rect_counter), 0);
        chk({tag, " batch_counter"}, 32'(batch_counter), 0);
        chk({tag, " batch_completed"}, 32'(batch_completed), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " done"}, 32'(done), 0);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor for the main DUT
    exp_t m;
    always @(negedge clk) begin
        if (tx_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected word", 32'(tx_valid), 0);
            end else begin
                m = sb.pop_front();
                chk("tx_data", 32'(tx_data), 32'(m.data));
                chk("coord_generator", 32'(coord_generator), 32'(m.k));
                chk("fsm_state", 32'(fsm_state), 32'(m.f));
                chk("rect_counter", 32'(rect_counter), 32'(m.r));
                chk("batch_counter", 32'(batch_counter), 32'(m.b));
                chk("batch_completed", 32'(batch_completed), 32'(m.bc));
                chk("word cycle", 32'(cyc), 32'(m.at));
                for (int i = 0; i < 6; i++) begin
                    if (int'(m.k) == hk[i]) begin
                        chk("hand fsm_state", 32'(fsm_state), 32'(hf[i]));
                        chk("hand rect_counter", 32'(rect_counter), 32'(hr[i]));
                        chk("hand batch_counter", 32'(batch_counter), 32'(hb[i]));
                    end
                end
            end
        end else begin
            chk("batch_completed without tx_valid", 32'(batch_completed), 0);
        end
        if (copy_start) begin
            if (exp_copy.size() == 0) chk("unexpected copy_start", 32'(copy_start), 0);
            else chk("copy_start cycle", 32'(cyc), 32'(exp_copy.pop_front()));
        end
        if (done) begin
            if (exp_done.size() == 0) chk("unexpected done", 32'(done), 0);
            else chk("done cycle", 32'(cyc), 32'(exp_done.pop_front()));
        end
    end

    // Monitor for the wrapping-address DUT
    int          wk_addr = 0;
    int          wk_data = 0;
    logic [15:0] wa;
    always @(negedge clk) begin
        if (w_mem_re) begin
            wa = 16'hFFF0 + 16'(wk_addr);
            chk("wrap mem_addr", 32'(w_mem_addr), 32'(wa));
            if (wk_addr == 16) chk("wrap to zero at k=16", 32'(w_mem_addr), 0);
            wk_addr++;
        end
        if (w_tx_valid) begin
            chk("wrap tx_data", 32'(w_tx_data), 32'(16'(wk_data) ^ 16'hA5A5));
            wk_data++;
        end
    end

    int s;
    initial begin
        reset       = 1'b1;
        frame_start = 1'b0;
        fs_w        = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_zero("reset");

        // Full frame on both DUTs
        @(posedge clk);
        #1;
        s = cyc;
        frame_start = 1'b1;
        fs_w        = 1'b1;
        push_frame(s);
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        fs_w        = 1'b0;
        wait_until(s + N + 10);
        chk("frame1 words left", 32'(sb.size()), 0);
        chk("wrap addresses issued", 32'(wk_addr), N);
        chk("wrap words received", 32'(wk_data), N);

        // frame_start held high: one copy per frame, next copy once IDLE is re-entered
        @(posedge clk);
        #1;
        s = cyc;
        frame_start = 1'b1;
        push_frame(s);
        push_frame(s + N + 4);
        wait_until(s + N + 6);
        frame_start = 1'b0;
        wait_until(s + 2 * N + 20);
        chk("held frames words left", 32'(sb.size()), 0);
        chk("held frames copy_start left", 32'(exp_copy.size()), 0);
        chk("held frames done left", 32'(exp_done.size()), 0);

        // Reset in the middle of a frame, at word k=100
        @(posedge clk);
        #1;
        s = cyc;
        frame_start = 1'b1;
        push_frame(s);
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        wait_until(s + 103);
        reset = 1'b1;
        chk("word in flight at reset", 32'(sb[0].k), 100);
        while (sb.size() > 1) sb.delete(sb.size() - 1);
        exp_done.delete();
        @(posedge clk);
        @(negedge clk);
        check_zero("mid-frame reset");
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("aborted frame words left", 32'(sb.size()), 0);

        // Clean frame after the abort
        s = cyc;
        frame_start = 1'b1;
        push_frame(s);
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        wait_until(s + N + 10);
        chk("recovery frame words left", 32'(sb.size()), 0);
        chk("recovery done left", 32'(exp_done.size()), 0);

        // Long idle stretch with no trigger
        repeat (1000) begin
            @(negedge clk);
            chk("idle mem_re", 32'(mem_re), 0);
            chk("idle tx_valid", 32'(tx_valid), 0);
            chk("idle busy", 32'(busy), 0);
        end

        chk("final copy_start left", 32'(exp_copy.size()), 0);
        chk("final done left", 32'(exp_done.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
